// File: rtl/iob_pkg.sv
// Shared types and helpers for the IOB responder.
// States, window sizing and byte-lane merge.
package iob_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WAIT,
      S_ACK,
      S_VWAIT,
      S_VSYNC,
      S_BERR,
      S_HOLD
   } state_t;

   localparam logic [4:0] OFFS_MAPPED = 5'd8;
   localparam int         SYNC_DEPTH  = 2;

   // Strobed lanes take bus data, the other lane keeps its old byte.
   function automatic logic [15:0] lane_merge(
      input logic [15:0] old_v,
      input logic [15:0] din,
      input logic        uds_n,
      input logic        lds_n
   );
      return {uds_n ? old_v[15:8] : din[15:8],
              lds_n ? old_v[7:0]  : din[7:0]};
   endfunction

endpackage

// File: rtl/iob_sync.sv
// Multi-flop synchronizer for asynchronous IOB controls.
// Reset loads the idle level of each bit.
module iob_sync
   import iob_pkg::*;
#(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [W-1:0]  i_d,
   output logic [W-1:0]  o_q
);

   logic [W-1:0] r_s [SYNC_DEPTH];

   // Shift the raw inputs through the synchronizer chain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < SYNC_DEPTH; i++) r_s[i] <= RST_VAL;
      end else begin
         r_s[0] <= i_d;
         for (int i = 1; i < SYNC_DEPTH; i++) r_s[i] <= r_s[i-1];
      end
   end

   assign o_q = r_s[SYNC_DEPTH-1];

endmodule

// File: rtl/iob_resp.sv
// IOB bus slave: async 68000 register window plus
// a 6800/VPA window, with bus error on unmapped offsets.
module iob_resp
   import iob_pkg::*;
#(
   parameter logic [18:0] BASE  = 19'h7FF80,
   parameter logic [18:0] VBASE = 19'h7FF81,
   parameter int unsigned WS    = 2
) (
   input  logic         C16M,
   input  logic         RES,
   input  logic [23:1]  A,
   input  logic         nAS,
   input  logic         nUDS,
   input  logic         nLDS,
   input  logic         RnW,
   input  logic         nVMA,
   input  logic         E,
   input  logic [15:0]  DIN,
   output logic [15:0]  DOUT,
   output logic         DOE,
   output logic         nDTACK,
   output logic         nVPA,
   output logic         nBERR
);

   logic [5:0]  w_sync;
   logic        w_as_n, w_uds_n, w_lds_n, w_rnw, w_vma_n, w_e;
   logic [18:0] w_win;
   logic [3:0]  w_off;
   logic [2:0]  w_idx;
   logic        w_mapped, w_hit_a, w_hit_v, w_in_win, w_efall;
   logic        w_acc, w_drv, w_wr;
   logic [2:0]  w_ws;
   state_t      w_nxt;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [23:1] r_addr;
   logic        r_rnw;
   logic        r_e_prev;
   logic [15:0] r_reg [8];
   logic [15:0] r_dout;
   logic        r_doe, r_dtack_n, r_vpa_n, r_berr_n;

   iob_sync #(
      .W       (6),
      .RST_VAL (6'b111110)
   ) u_sync (
      .i_clk (C16M),
      .i_rst (RES),
      .i_d   ({nAS, nUDS, nLDS, RnW, nVMA, E}),
      .o_q   (w_sync)
   );

   assign {w_as_n, w_uds_n, w_lds_n, w_rnw, w_vma_n, w_e} = w_sync;

   assign w_ws     = 3'(WS);
   assign w_win    = r_addr[23:5];
   assign w_off    = r_addr[4:1];
   assign w_idx    = w_off[2:0];
   assign w_mapped = {1'b0, w_off} < OFFS_MAPPED;
   assign w_hit_a  = (w_win == BASE) && w_mapped;
   assign w_hit_v  = (w_win == VBASE) && w_mapped;
   assign w_in_win = (w_win == BASE) || (w_win == VBASE);
   assign w_efall  = r_e_prev & ~w_e;
   assign w_wr     = w_acc & ~r_rnw;

   // Next state plus access/drive strobes for this cycle.
   always_comb begin
      w_nxt = r_state;
      w_acc = 1'b0;
      w_drv = 1'b0;
      unique case (r_state)
         S_IDLE:
            if (!w_as_n && (!w_uds_n || !w_lds_n))
               w_nxt = S_DECODE;
         S_DECODE:
            if (w_as_n) begin
               w_nxt = S_IDLE;
            end else if (w_hit_a) begin
               w_drv = r_rnw;
               if (w_ws == 3'd0) begin
                  w_nxt = S_ACK;
                  w_acc = 1'b1;
               end else begin
                  w_nxt = S_WAIT;
               end
            end else if (w_hit_v) begin
               w_nxt = S_VWAIT;
            end else if (w_in_win) begin
               w_nxt = S_BERR;
            end else begin
               w_nxt = S_HOLD;
            end
         S_WAIT:
            if (w_as_n) begin
               w_nxt = S_IDLE;
            end else if (r_cnt <= 3'd1) begin
               w_nxt = S_ACK;
               w_acc = 1'b1;
            end
         S_ACK:
            w_nxt = S_HOLD;
         S_VWAIT:
            if (w_as_n) begin
               w_nxt = S_IDLE;
            end else if (!w_vma_n) begin
               w_nxt = S_VSYNC;
               w_drv = r_rnw;
            end
         S_VSYNC:
            if (w_as_n) begin
               w_nxt = S_IDLE;
            end else if (w_efall) begin
               w_nxt = S_HOLD;
               w_acc = 1'b1;
            end
         S_BERR:
            w_nxt = S_HOLD;
         S_HOLD:
            if (w_as_n) w_nxt = S_IDLE;
      endcase
   end

   // State, wait counter, latched address and E history.
   always_ff @(posedge C16M or posedge RES) begin
      if (RES) begin
         r_state  <= S_IDLE;
         r_cnt    <= 3'd0;
         r_addr   <= '0;
         r_rnw    <= 1'b1;
         r_e_prev <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_e_prev <= w_e;
         if (r_state == S_IDLE && w_nxt == S_DECODE) begin
            r_addr <= A;
            r_rnw  <= w_rnw;
         end
         if (r_state == S_DECODE)
            r_cnt <= w_ws;
         else if (r_state == S_WAIT)
            r_cnt <= r_cnt - 3'd1;
      end
   end

   // Registered bus outputs; IDLE releases everything.
   always_ff @(posedge C16M or posedge RES) begin
      if (RES) begin
         r_dout    <= '0;
         r_doe     <= 1'b0;
         r_dtack_n <= 1'b1;
         r_vpa_n   <= 1'b1;
         r_berr_n  <= 1'b1;
      end else if (w_nxt == S_IDLE) begin
         r_doe     <= 1'b0;
         r_dtack_n <= 1'b1;
         r_vpa_n   <= 1'b1;
         r_berr_n  <= 1'b1;
      end else begin
         if (w_drv) begin
            r_doe  <= 1'b1;
            r_dout <= r_reg[w_idx];
         end
         if (w_nxt == S_ACK)   r_dtack_n <= 1'b0;
         if (w_nxt == S_VWAIT) r_vpa_n   <= 1'b0;
         if (w_nxt == S_BERR)  r_berr_n  <= 1'b0;
      end
   end

   // Register file, written per lane at the access point.
   always_ff @(posedge C16M or posedge RES) begin
      if (RES) begin
         for (int i = 0; i < 8; i++) r_reg[i] <= '0;
      end else if (w_wr) begin
         r_reg[w_idx] <= lane_merge(r_reg[w_idx], DIN,
                                    w_uds_n, w_lds_n);
      end
   end

   assign DOUT   = r_dout;
   assign DOE    = r_doe;
   assign nDTACK = r_dtack_n;
   assign nVPA   = r_vpa_n;
   assign nBERR  = r_berr_n;

endmodule

// File: tb/tb_iob_resp.sv
// Directed bench for iob_resp: async, VPA, bus error,
// unmapped, abort and reset-mid-cycle scenarios.
module tb_iob_resp;

   localparam logic [18:0] BASE  = 19'h7FF80;
   localparam logic [18:0] VBASE = 19'h7FF81;

   logic        C16M, RES;
   logic [23:1] A;
   logic        nAS, nUDS, nLDS, RnW, nVMA, E;
   logic [15:0] DIN, DOUT;
   logic        DOE, nDTACK, nVPA, nBERR;

   int n_chk = 0;
   int n_err = 0;

   iob_resp #(.BASE(BASE), .VBASE(VBASE), .WS(2)) dut (
      .C16M(C16M), .RES(RES), .A(A),
      .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .RnW(RnW),
      .nVMA(nVMA), .E(E), .DIN(DIN), .DOUT(DOUT),
      .DOE(DOE), .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR)
   );

   initial C16M = 1'b0;
   always #5 C16M = ~C16M;

   // E toggles every 5 clocks: 10-cycle period.
   initial begin
      E = 1'b0;
      forever begin
         repeat (5) @(posedge C16M);
         #3 E = ~E;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge C16M);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [18:0] win, input logic [3:0] off,
                        input logic rnw, input logic uds_n,
                        input logic lds_n, input logic [15:0] d);
      A    = {win, off};
      DIN  = d;
      RnW  = rnw;
      nUDS = uds_n;
      nLDS = lds_n;
      nAS  = 1'b0;
   endtask

   task automatic rel(input string tag);
      nAS  = 1'b1;
      nUDS = 1'b1;
      nLDS = 1'b1;
      nVMA = 1'b1;
      RnW  = 1'b1;
      tick(3);
      chk({tag, "_rel"},
          {12'd0, nDTACK, nVPA, nBERR, DOE}, 16'h000E);
   endtask

   task automatic wr(input logic [3:0] off, input logic uds_n,
                     input logic lds_n, input logic [15:0] d,
                     input string tag);
      start(BASE, off, 1'b0, uds_n, lds_n, d);
      tick(6);
      chk({tag, "_ack"}, 16'(nDTACK), 16'h0000);
      chk({tag, "_doe"}, 16'(DOE), 16'h0000);
      rel(tag);
   endtask

   task automatic rd(input logic [3:0] off, input logic [15:0] exp,
                     input string tag);
      start(BASE, off, 1'b1, 1'b0, 1'b0, 16'h0000);
      tick(4);
      chk({tag, "_doe"}, 16'(DOE), 16'h0001);
      chk({tag, "_dout"}, DOUT, exp);
      tick(2);
      chk({tag, "_ack"}, 16'(nDTACK), 16'h0000);
      rel(tag);
   endtask

   initial begin
      logic quiet;
      RES = 1'b1;
      A = '0; DIN = '0;
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      RnW = 1'b1; nVMA = 1'b1;
      tick(3);
      chk("rst_outs", {12'd0, nDTACK, nVPA, nBERR, DOE}, 16'h000E);
      chk("rst_dout", DOUT, 16'h0000);
      RES = 1'b0;
      tick(3);

      // Word write off 3, timed nDTACK and release.
      start(BASE, 4'd3, 1'b0, 1'b0, 1'b0, 16'hA55A);
      tick(5);
      chk("w3_dtack_c5", 16'(nDTACK), 16'h0001);
      tick(1);
      chk("w3_dtack_c6", 16'(nDTACK), 16'h0000);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      tick(2);
      chk("w3_hold_c2", 16'(nDTACK), 16'h0000);
      tick(1);
      chk("w3_rel_c3", 16'(nDTACK), 16'h0001);
      tick(2);
      rd(4'd3, 16'hA55A, "r3");

      // Byte lanes on off 0.
      wr(4'd0, 1'b0, 1'b1, 16'h1234, "wu0");
      rd(4'd0, 16'h1200, "ru0");
      wr(4'd0, 1'b1, 1'b0, 16'h00CD, "wl0");
      rd(4'd0, 16'h12CD, "rl0");

      // VPA read of off 1.
      wr(4'd1, 1'b0, 1'b0, 16'hBEEF, "w1");
      start(VBASE, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000);
      tick(4);
      chk("v_vpa", 16'(nVPA), 16'h0000);
      chk("v_doe0", 16'(DOE), 16'h0000);
      tick(4);
      nVMA = 1'b0;
      tick(2);
      chk("v_doe_pre", 16'(DOE), 16'h0000);
      tick(1);
      chk("v_doe", 16'(DOE), 16'h0001);
      chk("v_dout", DOUT, 16'hBEEF);
      chk("v_dtack", 16'(nDTACK), 16'h0001);
      tick(12);
      chk("v_hold", 16'(nVPA), 16'h0000);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nVMA = 1'b1;
      tick(2);
      chk("v_rel_c2", 16'(nVPA), 16'h0000);
      tick(1);
      chk("v_rel_c3", {14'd0, nVPA, DOE}, 16'h0002);
      tick(2);

      // VPA write of off 2.
      start(VBASE, 4'd2, 1'b0, 1'b0, 1'b0, 16'h5A5A);
      tick(5);
      nVMA = 1'b0;
      tick(16);
      chk("vw_doe", 16'(DOE), 16'h0000);
      rel("vw");
      rd(4'd2, 16'h5A5A, "rv2");

      // Unmapped off 9 in BASE window.
      start(BASE, 4'd9, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      tick(4);
      chk("be_outs", {13'd0, nDTACK, nVPA, nBERR}, 16'h0006);
      tick(3);
      chk("be_hold", 16'(nBERR), 16'h0000);
      rel("be");
      rd(4'd1, 16'hBEEF, "rbe1");

      // Outside both windows: nothing responds.
      start(19'h12345, 4'd3, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      quiet = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (!nDTACK || !nVPA || !nBERR || DOE) quiet = 1'b0;
      end
      chk("nomatch_quiet", 16'(quiet), 16'h0001);
      rel("nm");

      // Abort during WAIT: no write, no ack.
      start(BASE, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick(2);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (!nDTACK) quiet = 1'b0;
      end
      chk("abort_noack", 16'(quiet), 16'h0001);
      rd(4'd3, 16'hA55A, "rab3");

      // Reset during ACK of a write.
      start(BASE, 4'd5, 1'b0, 1'b0, 1'b0, 16'h7777);
      tick(6);
      chk("rm_ack", 16'(nDTACK), 16'h0000);
      RES = 1'b1;
      #1;
      chk("rm_outs", {12'd0, nDTACK, nVPA, nBERR, DOE}, 16'h000E);
      tick(1);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      RES = 1'b0;
      tick(3);
      rd(4'd5, 16'h0000, "rrm5");
      rd(4'd3, 16'h0000, "rrm3");
      rd(4'd1, 16'h0000, "rrm1");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
